ddr_rd_unpack: RTL and testbench

Downstream stage of the DDR address/controller top. Accepts 32-bit words read back from DDR (strobed by `write_fifo`) into a small word FIFO in the `phy_clk` domain. Unpacks each word into two 16-bit samples for the wavelet stage. Drives the `empty` read-request back to the DDR controller under a credit scheme, so that an accepted read burst can never overflow the buffer.

---
 rtl/ddr_rd_unpack.sv | 120 ++++++++++++
 tb/tb_ddr_rd_unpack.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_unpack.sv
// ddr_rd_unpack
//   Buffers 32-bit words read back from DDR in a small word FIFO and unpacks
//   each word into two 16-bit samples (low half first) for the wavelet stage.
//   The read request back to the DDR controller ("empty") is driven by a
//   credit scheme. The request stays high only while the buffer can still
//   absorb a full burst on top of the words already stored and the words
//   already promised. An accepted burst therefore can never overflow the FIFO.
//
// Ports
//   clk          phy_clk, all logic on the rising edge
//   reset        asynchronous, active-low
//   write_fifo   DDR read-data valid, rdata captured this cycle
//   rdata        DDR read word, [15:0] older sample, [31:16] newer sample
//   rd_addr_up   one-cycle pulse: a read burst was accepted by the controller
//   empty        registered read request to the controller
//   sample       current output sample
//   sample_valid sample is valid (FIFO holds at least one word)
//   sample_ready wavelet stage accepts the sample
//   level        number of stored words, 0..2^DEPTH_LOG2
//   overflow     sticky: a word arrived while the FIFO was full
module ddr_rd_unpack #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH_LOG2   = 5,
  parameter int BURST_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_fifo,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rd_addr_up,
  output logic                    empty,
  output logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [DEPTH_LOG2:0]     level,
  output logic                    overflow
);

  localparam int              DEPTH   = 1 << DEPTH_LOG2;
  localparam int              CW      = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   BURST_C = CW'(BURST_LEN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         pending;
  logic                  phase;

  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         pending_nxt;
  logic [DATA_WIDTH-1:0] head_word;

  // Outstanding-credit update: a new burst adds BURST_LEN, each accepted
  // word retires one. The retire saturates at zero, so unsolicited data does
  // not wrap the counter. The add saturates at all-ones, so a controller that
  // keeps accepting bursts beyond the request cannot wrap it either.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic          add,
                                                input logic          take);
    logic [CW:0] sum;
    sum = {1'b0, cur} + (add ? {1'b0, BURST_C} : {(CW+1){1'b0}});
    if (take && (sum != '0)) sum = sum - (CW+1)'(1);
    if (sum[CW]) return '1;
    return sum[CW-1:0];
  endfunction

  // Room for another burst once stored and promised words are accounted for.
  // Signed so that over-committed credit (negative room) compares correctly.
  function automatic logic burst_room(input logic [CW-1:0] cnt,
                                      input logic [CW-1:0] pend);
    logic signed [CW+1:0] room;
    room = $signed({2'b00, DEPTH_C}) - $signed({2'b00, cnt})
         - $signed({2'b00, pend});
    return room >= $signed({2'b00, BURST_C});
  endfunction

  assign push         = write_fifo && (count != DEPTH_C);
  assign sample_valid = (count != '0);
  // A word leaves the FIFO only when its upper (second) half is taken.
  assign pop          = sample_valid && sample_ready && phase;
  assign count_nxt    = count + CW'(push) - CW'(pop);
  assign pending_nxt  = credit_next(pending, rd_addr_up, push);
  assign level        = count;

  // Sample comes straight from the stored head word, so it holds steady for
  // as long as rptr and phase do, which is across any stall.
  assign head_word    = mem[rptr];
  assign sample       = phase ? head_word[DATA_WIDTH-1 -: SAMPLE_WIDTH]
                              : head_word[SAMPLE_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pending  <= '0;
      phase    <= 1'b0;
      overflow <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push) wptr <= wptr + DEPTH_LOG2'(1);
      if (write_fifo && !push) overflow <= 1'b1;
      if (sample_valid && sample_ready) phase <= ~phase;
      if (pop) rptr <= rptr + DEPTH_LOG2'(1);
      count   <= count_nxt;
      pending <= pending_nxt;
      empty   <= burst_room(count_nxt, pending_nxt);
    end
  end

endmodule

// File: tb/tb_ddr_rd_unpack.sv
// Directed bench for ddr_rd_unpack. A scoreboard queue receives the two
// expected samples of every word the DUT should accept, and entries are
// popped and compared as samples are handed over.
module tb_ddr_rd_unpack;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_fifo = 1'b0;
  logic [31:0] rdata = '0;
  logic        rd_addr_up = 1'b0;
  logic        empty;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic [5:0]  level;
  logic        overflow;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] q[$];
  int          mcount = 0;
  bit          mphase = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] prev_sample = '0;
  int          nsamp = 0;

  ddr_rd_unpack #(
    .DATA_WIDTH(32), .SAMPLE_WIDTH(16), .DEPTH_LOG2(5), .BURST_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .write_fifo(write_fifo), .rdata(rdata),
    .rd_addr_up(rd_addr_up), .empty(empty), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: check outputs on the falling edge, let the rising edge happen,
  // then advance the model with the inputs that were applied to that edge.
  task automatic tick();
    bit          hs;
    bit          acc;
    logic [15:0] exp;
    @(negedge clk);
    chk("sample_valid", 32'(sample_valid), 32'(mcount != 0));
    if (stall_prev) chk("stall_stable", 32'(sample), 32'(prev_sample));
    hs = (mcount != 0) && sample_ready;
    if (hs) begin
      exp = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
      chk("sample", 32'(sample), 32'(exp));
      nsamp++;
    end
    stall_prev  = (mcount != 0) && !sample_ready;
    prev_sample = sample;
    acc = write_fifo && (mcount < 32);
    @(posedge clk);
    #1;
    if (hs) begin
      if (mphase) begin
        mcount--;
        mphase = 1'b0;
      end else begin
        mphase = 1'b1;
      end
    end
    if (acc) begin
      q.push_back(rdata[15:0]);
      q.push_back(rdata[31:16]);
      mcount++;
    end
  endtask

  task automatic model_clear();
    q.delete();
    mcount     = 0;
    mphase     = 1'b0;
    stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    write_fifo = 1'b0;
    rd_addr_up = 1'b0;
    #2;
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic pulse();
    rd_addr_up = 1'b1;
    tick();
    rd_addr_up = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] w);
    write_fifo = 1'b1;
    rdata      = w;
    tick();
    write_fifo = 1'b0;
  endtask

  initial begin
    int sent;
    int s0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Single word, low half first
    sample_ready = 1'b1;
    pulse();
    chk("single_req", 32'(empty), 32'd1);
    write_word(32'hBBBB_AAAA);
    chk("single_latency_valid", 32'(sample_valid), 32'd1);
    chk("single_first", 32'(sample), 32'h0000_AAAA);
    chk("single_level", 32'(level), 32'd1);
    repeat (3) tick();
    chk("single_drained_valid", 32'(sample_valid), 32'd0);
    chk("single_drained_level", 32'(level), 32'd0);

    // Credit exhaustion with the consumer stalled
    do_reset();
    sample_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pulse();
      chk($sformatf("credit_pulse%0d_empty", k), 32'(empty), 32'(k < 8));
      for (int j = 0; j < 4; j++) write_word($urandom);
    end
    chk("credit_level_full", 32'(level), 32'd32);
    chk("credit_empty_low", 32'(empty), 32'd0);
    sample_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("credit_pop%0d_empty", i), 32'(empty), 32'(i == 8));
    end
    sample_ready = 1'b0;
    chk("credit_level_after_pops", 32'(level), 32'd28);

    // Refill to full, then one dropped word
    pulse();
    chk("refill_req_low", 32'(empty), 32'd0);
    for (int j = 0; j < 4; j++) write_word(32'hC0DE_0000 | 32'(j));
    chk("ovf_level_full", 32'(level), 32'd32);
    chk("ovf_before", 32'(overflow), 32'd0);
    write_word(32'hDEAD_BEEF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level_kept", 32'(level), 32'd32);
    sample_ready = 1'b1;
    for (int c = 0; c < 200 && mcount != 0; c++) tick();
    chk("ovf_drained_level", 32'(level), 32'd0);
    chk("ovf_drained_sb", 32'(q.size()), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Random back-pressure while streaming 100 incrementing words
    do_reset();
    chk("ovf_cleared_by_reset", 32'(overflow), 32'd0);
    sent = 0;
    s0   = nsamp;
    for (int c = 0; c < 4000 && !(sent == 100 && mcount == 0); c++) begin
      sample_ready = 1'($urandom_range(0, 1));
      rd_addr_up   = (sent % 4 == 0) && (sent < 100) && ($urandom_range(0, 3) == 0);
      write_fifo   = (sent < 100) && (mcount < 28) && ($urandom_range(0, 1) == 1);
      if (write_fifo) begin
        rdata = {16'(2 * sent + 1), 16'(2 * sent)};
        sent++;
      end
      tick();
    end
    write_fifo   = 1'b0;
    rd_addr_up   = 1'b0;
    chk("stream_words_sent", 32'(sent), 32'd100);
    chk("stream_samples", 32'(nsamp - s0), 32'd200);
    chk("stream_level", 32'(level), 32'd0);
    chk("stream_overflow", 32'(overflow), 32'd0);

    // Reset in the middle of activity: level 10, pending 3
    do_reset();
    sample_ready = 1'b0;
    repeat (4) pulse();
    for (int j = 0; j < 13; j++) write_word($urandom);
    sample_ready = 1'b1;
    repeat (6) tick();
    sample_ready = 1'b0;
    chk("mid_level_before", 32'(level), 32'd10);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    // Seven bursts fit only if the old credit was really discarded.
    repeat (7) pulse();
    chk("mid_credit_cleared", 32'(empty), 32'd1);
    sample_ready = 1'b1;
    write_word(32'h5678_1234);
    chk("mid_first_sample", 32'(sample), 32'h0000_1234);
    repeat (3) tick();
    chk("mid_drained_level", 32'(level), 32'd0);
    chk("mid_drained_sb", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
